// File: rtl/vga_pattern_gen.sv
// VGA timing counters plus registered multi-mode test-pattern generator.
// Optional macro BORDER_OVERLAY_EN forces a white one-pixel frame around the active area.
module vga_pattern_gen #(
  parameter int unsigned COLOR_BITS   = 4,
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned H_FP         = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BP         = 48,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned V_FP         = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BP         = 33,
  parameter bit          SYNC_POL     = 1'b0,
  parameter int unsigned CHECKER_LOG2 = 5
) (
  input  logic                    clock25MHz,
  input  logic                    nReset,
  input  logic [2:0]              mode,
  input  logic [3*COLOR_BITS-1:0] solidColor,
  output logic [COLOR_BITS-1:0]   red,
  output logic [COLOR_BITS-1:0]   green,
  output logic [COLOR_BITS-1:0]   blue,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    canDisplayImage,
  output logic [9:0]              x,
  output logic [9:0]              y,
  output logic                    frameStart
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned CW      = 16;
  localparam int unsigned BAR_W   = H_ACTIVE / 8;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SYNC_S = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SYNC_E = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SYNC_S = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SYNC_E = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [COLOR_BITS-1:0] FULL = '1;

  logic [CW-1:0]         r_h_cnt, r_v_cnt;
  logic [7:0]            r_frame_cnt;
  logic [2:0]            r_active_mode;
  logic [COLOR_BITS-1:0] r_red, r_green, r_blue;
  logic                  r_hsync, r_vsync, r_de, r_fs;
  logic [9:0]            r_x, r_y;

  logic                  w_h_wrap, w_frame_end, w_active, w_hs_act, w_vs_act;
  logic                  w_in_sq, w_border, w_chk;
  logic [CW-1:0]         w_bar, w_sq_x, w_sq_y;
  logic [2:0]            w_bar_idx;
  logic [COLOR_BITS-1:0] w_r, w_g, w_b;

  assign w_h_wrap    = (r_h_cnt == H_LAST);
  assign w_frame_end = w_h_wrap && (r_v_cnt == V_LAST);

  always_ff @(posedge clock25MHz or negedge nReset) begin
    if (!nReset) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_frame_cnt   <= '0;
      r_active_mode <= '0;
    end else begin
      r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + CW'(1);
      if (w_h_wrap) r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CW'(1);
      // Mode and animation step only change between frames so no frame is torn.
      if (w_frame_end) begin
        r_active_mode <= mode;
        r_frame_cnt   <= r_frame_cnt + 8'd1;
      end
    end
  end

  assign w_active  = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hs_act  = (r_h_cnt >= H_SYNC_S) && (r_h_cnt < H_SYNC_E);
  assign w_vs_act  = (r_v_cnt >= V_SYNC_S) && (r_v_cnt < V_SYNC_E);
  assign w_bar     = r_h_cnt / CW'(BAR_W);
  assign w_bar_idx = (w_bar > CW'(7)) ? 3'd7 : w_bar[2:0];
  assign w_chk     = r_h_cnt[CHECKER_LOG2] ^ r_v_cnt[CHECKER_LOG2];
  assign w_sq_x    = CW'({r_frame_cnt, 1'b0});
  assign w_sq_y    = CW'(r_frame_cnt);
  // Clipping falls out of the active-area gate; the square never wraps.
  assign w_in_sq   = (r_h_cnt >= w_sq_x) && (r_h_cnt < w_sq_x + CW'(32)) &&
                     (r_v_cnt >= w_sq_y) && (r_v_cnt < w_sq_y + CW'(32));

`ifdef BORDER_OVERLAY_EN
  assign w_border = (r_h_cnt == '0) || (r_h_cnt == H_ACT - CW'(1)) ||
                    (r_v_cnt == '0) || (r_v_cnt == V_ACT - CW'(1));
`else
  assign w_border = 1'b0;
`endif

  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    case (r_active_mode)
      3'd0: {w_r, w_g, w_b} = solidColor;
      3'd1: begin
        // Bar index bits map straight onto white..black channel enables.
        w_r = {COLOR_BITS{~w_bar_idx[1]}};
        w_g = {COLOR_BITS{~w_bar_idx[2]}};
        w_b = {COLOR_BITS{~w_bar_idx[0]}};
      end
      3'd2: if (w_chk) {w_r, w_g, w_b} = {FULL, FULL, FULL};
      3'd3: begin
        w_r = r_h_cnt[COLOR_BITS+3:4];
        w_g = r_h_cnt[COLOR_BITS+3:4];
        w_b = r_h_cnt[COLOR_BITS+3:4];
      end
      3'd4: if (w_in_sq) {w_r, w_g, w_b} = {FULL, FULL, FULL};
      default: ;
    endcase
    if (w_border) {w_r, w_g, w_b} = {FULL, FULL, FULL};
    if (!w_active) {w_r, w_g, w_b} = '0;
  end

  always_ff @(posedge clock25MHz or negedge nReset) begin
    if (!nReset) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
      r_hsync <= ~SYNC_POL;
      r_vsync <= ~SYNC_POL;
      r_de    <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_fs    <= 1'b0;
    end else begin
      r_red   <= w_r;
      r_green <= w_g;
      r_blue  <= w_b;
      r_hsync <= w_hs_act ? SYNC_POL : ~SYNC_POL;
      r_vsync <= w_vs_act ? SYNC_POL : ~SYNC_POL;
      r_de    <= w_active;
      r_x     <= w_active ? r_h_cnt[9:0] : '0;
      r_y     <= w_active ? r_v_cnt[9:0] : '0;
      r_fs    <= (r_h_cnt == '0) && (r_v_cnt == '0);
    end
  end

  assign red             = r_red;
  assign green           = r_green;
  assign blue            = r_blue;
  assign hsync           = r_hsync;
  assign vsync           = r_vsync;
  assign canDisplayImage = r_de;
  assign x               = r_x;
  assign y               = r_y;
  assign frameStart      = r_fs;

endmodule
